// File: rtl/fdd_drive_mech.sv
// rtl/fdd_drive_mech.sv - floppy drive mechanics model: head stepper, spindle rotation, status lines
module fdd_drive_mech #(
   parameter int MAX_TRACK  = 81,
   parameter int ROT_MS     = 200,
   parameter int INDEX_MS   = 4,
   parameter int SPINUP_REV = 2
) (
   input  logic       clk,
   input  logic       MRn,
   input  logic       msclk,
   input  logic       STEPn,
   input  logic       SDIRn,
   input  logic       MOTORn,
   input  logic       disk_inserted,
   input  logic       disk_wp,
   output logic       TRK00n,
   output logic       INDEXn,
   output logic       READYn,
   output logic       WPROTn,
   output logic       DSKCHGn,
   output logic [6:0] head_track,
   output logic [7:0] rot_pos,
   output logic       step_done
);

   typedef enum logic {
      ROT_STOP = 1'b0,
      ROT_SPIN = 1'b1
   } rot_state_e;

   localparam logic [6:0] TRACK_MAX = 7'(MAX_TRACK);
   localparam logic [7:0] ROT_LAST  = 8'(ROT_MS - 1);
   localparam logic [7:0] INDEX_W   = 8'(INDEX_MS);
   localparam logic [7:0] REV_READY = 8'(SPINUP_REV);

   rot_state_e state_q, state_d;
   logic [6:0] track_q, track_d;
   logic [7:0] rot_q, rot_d;
   logic [7:0] rev_q, rev_d;
   logic       stepn_q;
   logic       disk_q;
   logic       dskchg_n_q, dskchg_n_d;
   logic       step_done_q, step_done_d;

   logic       step_ev;
   logic       ins_edge;

   // falling edge of STEPn against its registered copy; media edge against registered presence
   assign step_ev  = stepn_q & ~STEPn;
   assign ins_edge = disk_q ^ disk_inserted;

   // head positioner: move one cylinder per accepted step, clamped at both mechanical stops
   always_comb begin
      track_d     = track_q;
      step_done_d = step_ev;
      if (step_ev) begin
         if (SDIRn) begin
            if (track_q < TRACK_MAX) begin
               track_d = track_q + 7'd1;
            end
         end else if (track_q != 7'd0) begin
            track_d = track_q - 7'd1;
         end
      end
   end

   // disk-change latch: a media edge always wins over a step that would clear it
   always_comb begin
      dskchg_n_d = dskchg_n_q;
      if (ins_edge) begin
         dskchg_n_d = 1'b0;
      end else if (step_ev && disk_inserted) begin
         dskchg_n_d = 1'b1;
      end
   end

   // spindle: position advances only while spinning; spin-up count restarts whenever it stops
   always_comb begin
      state_d = (!MOTORn && disk_inserted) ? ROT_SPIN : ROT_STOP;
      rot_d   = rot_q;
      rev_d   = rev_q;
      if (state_d == ROT_SPIN && msclk) begin
         if (rot_q == ROT_LAST) begin
            rot_d = 8'd0;
            if (rev_q < REV_READY) begin
               rev_d = rev_q + 8'd1;
            end
         end else begin
            rot_d = rot_q + 8'd1;
         end
      end
      if (state_d == ROT_STOP) begin
         rev_d = 8'd0;
      end
   end

   // all state registers; reset parks the head at cylinder 0 with the spindle stopped
   always_ff @(posedge clk or negedge MRn) begin
      if (!MRn) begin
         state_q     <= ROT_STOP;
         track_q     <= 7'd0;
         rot_q       <= 8'd0;
         rev_q       <= 8'd0;
         stepn_q     <= 1'b1;
         disk_q      <= 1'b0;
         dskchg_n_q  <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         track_q     <= track_d;
         rot_q       <= rot_d;
         rev_q       <= rev_d;
         stepn_q     <= STEPn;
         disk_q      <= disk_inserted;
         dskchg_n_q  <= dskchg_n_d;
         step_done_q <= step_done_d;
      end
   end

   assign head_track = track_q;
   assign rot_pos    = rot_q;
   assign step_done  = step_done_q;
   assign DSKCHGn    = dskchg_n_q;
   assign TRK00n     = ~(track_q == 7'd0);
   assign WPROTn     = ~(disk_inserted & disk_wp);
   assign INDEXn     = ~(state_q == ROT_SPIN && rot_q < INDEX_W);
   assign READYn     = ~(state_q == ROT_SPIN && rev_q >= REV_READY);

endmodule

// File: tb/tb_fdd_drive_mech.sv
// tb/tb_fdd_drive_mech.sv - directed self-checking bench for fdd_drive_mech
module tb_fdd_drive_mech;

   logic       clk = 1'b0;
   logic       MRn = 1'b0;
   logic       msclk = 1'b0;
   logic       STEPn = 1'b1;
   logic       SDIRn = 1'b1;
   logic       MOTORn = 1'b1;
   logic       disk_inserted = 1'b0;
   logic       disk_wp = 1'b0;
   logic       TRK00n, INDEXn, READYn, WPROTn, DSKCHGn, step_done;
   logic [6:0] head_track;
   logic [7:0] rot_pos;

   int n_cmp = 0;
   int n_bad = 0;
   int sd_count = 0;
   logic last_pulse = 1'b0;

   fdd_drive_mech dut (
      .clk(clk), .MRn(MRn), .msclk(msclk), .STEPn(STEPn), .SDIRn(SDIRn),
      .MOTORn(MOTORn), .disk_inserted(disk_inserted), .disk_wp(disk_wp),
      .TRK00n(TRK00n), .INDEXn(INDEXn), .READYn(READYn), .WPROTn(WPROTn),
      .DSKCHGn(DSKCHGn), .head_track(head_track), .rot_pos(rot_pos), .step_done(step_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (step_done === 1'b1) sd_count++;
   endtask

   task automatic step_pulse(input logic dir);
      SDIRn = dir;
      STEPn = 1'b0;
      tick();
      last_pulse = step_done;
      STEPn = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (head_track !== 7'd0) begin n_bad++; $display("FAIL reset_track got %0d want 0", head_track); end
      n_cmp++; if (rot_pos !== 8'd0) begin n_bad++; $display("FAIL reset_rot got %0d want 0", rot_pos); end
      n_cmp++; if (TRK00n !== 1'b0) begin n_bad++; $display("FAIL reset_trk00 got %b want 0", TRK00n); end
      n_cmp++; if (INDEXn !== 1'b1 || READYn !== 1'b1) begin n_bad++; $display("FAIL reset_idx_rdy got %b%b want 11", INDEXn, READYn); end
      n_cmp++; if (DSKCHGn !== 1'b0 || step_done !== 1'b0) begin n_bad++; $display("FAIL reset_chg_sd got %b%b want 00", DSKCHGn, step_done); end
      n_cmp++; if (WPROTn !== 1'b1) begin n_bad++; $display("FAIL reset_wprot got %b want 1", WPROTn); end
      tick();
      MRn = 1'b1;
      tick();
   endtask

   task automatic test_step_in();
      sd_count = 0;
      for (int i = 0; i < 5; i++) step_pulse(1'b1);
      n_cmp++; if (head_track !== 7'd5) begin n_bad++; $display("FAIL step_in_track got %0d want 5", head_track); end
      n_cmp++; if (TRK00n !== 1'b1) begin n_bad++; $display("FAIL step_in_trk00 got %b want 1", TRK00n); end
      n_cmp++; if (sd_count !== 5) begin n_bad++; $display("FAIL step_in_pulses got %0d want 5", sd_count); end
      n_cmp++; if (DSKCHGn !== 1'b0) begin n_bad++; $display("FAIL step_nodisk_chg got %b want 0", DSKCHGn); end
   endtask

   task automatic test_outer_limit();
      for (int i = 0; i < 4; i++) step_pulse(1'b0);
      n_cmp++; if (head_track !== 7'd1) begin n_bad++; $display("FAIL out_track1 got %0d want 1", head_track); end
      sd_count = 0;
      step_pulse(1'b0);
      step_pulse(1'b0);
      n_cmp++; if (head_track !== 7'd0) begin n_bad++; $display("FAIL out_limit_track got %0d want 0", head_track); end
      n_cmp++; if (TRK00n !== 1'b0) begin n_bad++; $display("FAIL out_limit_trk00 got %b want 0", TRK00n); end
      n_cmp++; if (last_pulse !== 1'b1 || sd_count !== 2) begin n_bad++; $display("FAIL out_limit_pulse got %b/%0d want 1/2", last_pulse, sd_count); end
   endtask

   task automatic test_inner_limit();
      for (int i = 0; i < 81; i++) step_pulse(1'b1);
      n_cmp++; if (head_track !== 7'd81) begin n_bad++; $display("FAIL in_track81 got %0d want 81", head_track); end
      step_pulse(1'b1);
      n_cmp++; if (head_track !== 7'd81) begin n_bad++; $display("FAIL in_limit_track got %0d want 81", head_track); end
      n_cmp++; if (last_pulse !== 1'b1) begin n_bad++; $display("FAIL in_limit_pulse got %b want 1", last_pulse); end
   endtask

   task automatic test_rotation();
      int bad_k;
      logic [7:0] exp_rot;
      logic exp_idx, exp_rdy;
      disk_inserted = 1'b1;
      MOTORn = 1'b0;
      msclk = 1'b0;
      tick();
      n_cmp++; if (rot_pos !== 8'd0 || INDEXn !== 1'b0 || READYn !== 1'b1) begin n_bad++; $display("FAIL rot_start got %0d/%b/%b want 0/0/1", rot_pos, INDEXn, READYn); end
      msclk = 1'b1;
      bad_k = -1;
      for (int k = 1; k <= 1010; k++) begin
         tick();
         exp_rot = 8'(k % 200);
         exp_idx = (k % 200 < 4) ? 1'b0 : 1'b1;
         exp_rdy = (k >= 400) ? 1'b0 : 1'b1;
         if (bad_k < 0 && (rot_pos !== exp_rot || INDEXn !== exp_idx || READYn !== exp_rdy)) begin
            bad_k = k;
            $display("cycle %0d: rot %0d idx %b rdy %b, want %0d %b %b", k, rot_pos, INDEXn, READYn, exp_rot, exp_idx, exp_rdy);
         end
      end
      n_cmp++; if (bad_k != -1) begin n_bad++; $display("FAIL rot_pattern got first bad tick %0d want none", bad_k); end
      MOTORn = 1'b1;
      tick();
      n_cmp++; if (READYn !== 1'b1 || INDEXn !== 1'b1) begin n_bad++; $display("FAIL motor_off got rdy %b idx %b want 1 1", READYn, INDEXn); end
      tick();
      n_cmp++; if (rot_pos !== 8'd10) begin n_bad++; $display("FAIL rot_hold got %0d want 10", rot_pos); end
      MOTORn = 1'b0;
      for (int k = 0; k < 195; k++) tick();
      n_cmp++; if (READYn !== 1'b1 || rot_pos !== 8'd205 - 8'd200) begin n_bad++; $display("FAIL respin_rdy got %b/%0d want 1/5", READYn, rot_pos); end
      MOTORn = 1'b1;
      msclk = 1'b0;
      tick();
   endtask

   task automatic test_dskchg();
      n_cmp++; if (DSKCHGn !== 1'b0) begin n_bad++; $display("FAIL chg_after_insert got %b want 0", DSKCHGn); end
      disk_inserted = 1'b0;
      tick();
      disk_inserted = 1'b1;
      tick();
      n_cmp++; if (DSKCHGn !== 1'b0) begin n_bad++; $display("FAIL chg_reinsert got %b want 0", DSKCHGn); end
      step_pulse(1'b0);
      n_cmp++; if (DSKCHGn !== 1'b1 || head_track !== 7'd80) begin n_bad++; $display("FAIL chg_clear got %b/%0d want 1/80", DSKCHGn, head_track); end
      disk_inserted = 1'b0;
      tick();
      n_cmp++; if (DSKCHGn !== 1'b0) begin n_bad++; $display("FAIL chg_remove got %b want 0", DSKCHGn); end
      SDIRn = 1'b0;
      STEPn = 1'b0;
      disk_inserted = 1'b1;
      tick();
      n_cmp++; if (DSKCHGn !== 1'b0 || head_track !== 7'd79 || step_done !== 1'b1) begin n_bad++; $display("FAIL chg_wins got %b/%0d/%b want 0/79/1", DSKCHGn, head_track, step_done); end
      STEPn = 1'b1;
      tick();
      disk_wp = 1'b1;
      #1;
      n_cmp++; if (WPROTn !== 1'b0) begin n_bad++; $display("FAIL wprot_on got %b want 0", WPROTn); end
      disk_wp = 1'b0;
      #1;
      n_cmp++; if (WPROTn !== 1'b1) begin n_bad++; $display("FAIL wprot_off got %b want 1", WPROTn); end
   endtask

   task automatic test_same_clk();
      MOTORn = 1'b0;
      msclk = 1'b0;
      tick();
      msclk = 1'b1;
      SDIRn = 1'b1;
      STEPn = 1'b0;
      tick();
      n_cmp++; if (rot_pos !== 8'd6 || head_track !== 7'd80) begin n_bad++; $display("FAIL same_clk got rot %0d trk %0d want 6 80", rot_pos, head_track); end
      STEPn = 1'b1;
      msclk = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 60; i++) step_pulse(1'b0);
      n_cmp++; if (head_track !== 7'd20) begin n_bad++; $display("FAIL pre_reset_track got %0d want 20", head_track); end
      msclk = 1'b1;
      for (int k = 0; k < 450; k++) tick();
      n_cmp++; if (READYn !== 1'b0 || rot_pos !== 8'd56) begin n_bad++; $display("FAIL pre_reset_spin got %b/%0d want 0/56", READYn, rot_pos); end
      STEPn = 1'b0;
      #1;
      MRn = 1'b0;
      #1;
      n_cmp++; if (head_track !== 7'd0 || rot_pos !== 8'd0) begin n_bad++; $display("FAIL mid_reset_pos got %0d/%0d want 0/0", head_track, rot_pos); end
      n_cmp++; if (READYn !== 1'b1 || INDEXn !== 1'b1 || TRK00n !== 1'b0) begin n_bad++; $display("FAIL mid_reset_lines got %b%b%b want 110", READYn, INDEXn, TRK00n); end
      STEPn = 1'b1;
      tick();
      MRn = 1'b1;
      sd_count = 0;
      for (int k = 0; k < 3; k++) tick();
      n_cmp++; if (sd_count !== 0 || head_track !== 7'd0) begin n_bad++; $display("FAIL post_reset_step got %0d/%0d want 0/0", sd_count, head_track); end
   endtask

   initial begin
      test_reset();
      test_step_in();
      test_outer_limit();
      test_inner_limit();
      test_rotation();
      test_dskchg();
      test_same_clk();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
